// File: rtl/mac_operand_feeder.sv
// ============================================================================
// mac_operand_feeder : streams one dot product per output channel into the MAC
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_operand_feeder #(
    parameter int LATENCY  = 4,
    parameter int CIN_MAX  = 64,
    parameter int COUT_MAX = 64,
    parameter int FADDR_W  = 6,
    parameter int WADDR_W  = 12,
    parameter int F_W      = 8,
    parameter int W_W      = 8,
    parameter int ACC_W    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [$clog2(CIN_MAX+1)-1:0]    cmd_cin,
    input  logic [$clog2(COUT_MAX+1)-1:0]   cmd_cout,
    input  logic [FADDR_W-1:0]              cmd_fbase,
    input  logic [WADDR_W-1:0]              cmd_wbase,
    output logic                            f_rd_en,
    output logic [FADDR_W-1:0]              f_rd_addr,
    input  logic [F_W-1:0]                  f_rd_data,
    output logic                            w_rd_en,
    output logic [WADDR_W-1:0]              w_rd_addr,
    input  logic [W_W-1:0]                  w_rd_data,
    output logic [F_W-1:0]                  mac_feature,
    output logic [W_W-1:0]                  mac_weight,
    output logic                            mac_valid,
    output logic                            mac_clear,
    input  logic [ACC_W-1:0]                mac_accum,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [ACC_W-1:0]                res_data,
    output logic [$clog2(COUT_MAX)-1:0]     res_idx,
    output logic                            res_last,
    output logic                            busy
);

    localparam int KW = $clog2(CIN_MAX + 1);
    localparam int NW = $clog2(COUT_MAX + 1);
    localparam int OW = $clog2(COUT_MAX);
    localparam int DW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_cmd_ready;
    logic [KW-1:0]      r_cin;
    logic [NW-1:0]      r_cout;
    logic [FADDR_W-1:0] r_fbase;
    logic [WADDR_W-1:0] r_wrow;
    logic [KW-1:0]      r_k;
    logic [OW-1:0]      r_o;
    logic [DW-1:0]      r_drain;
    logic               r_mac_valid;
    logic               r_mac_clear;
    logic [ACC_W-1:0]   r_res_data;

    logic               w_cmd_fire;
    logic               w_k_last;
    logic               w_drain_last;
    logic               w_last_ch;
    logic               w_rd;

    assign w_cmd_fire   = cmd_valid && r_cmd_ready;
    assign w_k_last     = (r_k == r_cin - KW'(1));
    assign w_drain_last = (r_drain == DW'(LATENCY));
    assign w_last_ch    = ((NW'(r_o) + NW'(1)) == r_cout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd         = 1'b0;
        f_rd_en      = 1'b0;
        w_rd_en      = 1'b0;
        f_rd_addr    = '0;
        w_rd_addr    = '0;
        res_valid    = 1'b0;
        res_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    if (cmd_cout == '0) begin
                        w_state_next = S_IDLE;
                    end else if (cmd_cin == '0) begin
                        w_state_next = S_OUT;
                    end else begin
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                w_rd      = 1'b1;
                f_rd_en   = 1'b1;
                w_rd_en   = 1'b1;
                f_rd_addr = r_fbase + FADDR_W'(r_k);
                w_rd_addr = r_wrow + WADDR_W'(r_k);
                if (w_k_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_last) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                res_last  = w_last_ch;
                if (res_ready) begin
                    if (w_last_ch) begin
                        w_state_next = S_IDLE;
                    end else if (r_cin == '0) begin
                        w_state_next = S_OUT;
                    end else begin
                        w_state_next = S_FETCH;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b0;
            r_cin       <= '0;
            r_cout      <= '0;
            r_fbase     <= '0;
            r_wrow      <= '0;
            r_k         <= '0;
            r_o         <= '0;
            r_drain     <= '0;
            r_mac_valid <= 1'b0;
            r_mac_clear <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_cmd_ready <= (w_state_next == S_IDLE);
            r_mac_valid <= w_rd;
            r_mac_clear <= w_rd && (r_k == '0);
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_cin      <= cmd_cin;
                        r_cout     <= cmd_cout;
                        r_fbase    <= cmd_fbase;
                        r_wrow     <= cmd_wbase;
                        r_k        <= '0;
                        r_o        <= '0;
                        r_res_data <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_k_last) begin
                        r_k     <= '0;
                        r_drain <= '0;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain + DW'(1);
                    if (w_drain_last) begin
                        r_res_data <= mac_accum;
                    end
                end
                S_OUT: begin
                    // Zeroing here is what a K==0 channel reports; K>0 overwrites it in DRAIN.
                    if (res_ready && !w_last_ch) begin
                        r_o        <= r_o + OW'(1);
                        r_wrow     <= r_wrow + WADDR_W'(r_cin);
                        r_res_data <= '0;
                    end
                end
                default: begin
                    r_k <= '0;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign busy        = (r_state != S_IDLE);
    assign mac_valid   = r_mac_valid;
    assign mac_clear   = r_mac_clear;
    assign mac_feature = r_mac_valid ? f_rd_data : '0;
    assign mac_weight  = r_mac_valid ? w_rd_data : '0;
    assign res_data    = r_res_data;
    assign res_idx     = r_o;

endmodule

`default_nettype wire
